// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
package if_stage_pkg;

  localparam int unsigned PC_W             = 32;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } if_state_e;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO holding {pc, instruction} entries between the fetch
// responses and the decoder. Flush wins over push and pop in the same cycle.
module if_fifo
  import if_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [WIDTH-1:0]         o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;

  assign w_do_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only observed while counted.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_full  = (r_count == DEPTH_V);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_stage.sv
// RV32I instruction fetch stage: owns the PC, issues in-order imem requests,
// buffers responses and discards stale ones after a redirect.
// Optional perf counters are built when IF_PERF_EN is defined.
// Handshake: a transfer to ID happens in any cycle where id_valid_o and
// id_ready_i are both high; the head entry is held until that happens.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] addr_o,
`ifdef IF_PERF_EN
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o,
`endif
  output if_state_e   dbg_state_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  if_state_e      r_state, w_state_nxt;
  logic [31:0]    r_fetch_pc, r_resp_pc, w_redirect_pc;
  logic [CW-1:0]  r_out_cnt, r_drop_cnt, w_out_nxt, w_fifo_cnt;
  logic [CW:0]    w_inflight;
  logic           w_req, w_gnt, w_drop, w_push, w_pop, w_empty, w_full;
  logic [63:0]    w_head;

  assign w_redirect_pc = redirect_pc_i & ~32'h3;
  assign w_inflight    = {1'b0, r_out_cnt} + {1'b0, w_fifo_cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_state_nxt;
  end

  // Credit check: outstanding plus buffered can never exceed the FIFO size.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN:  w_req       = (w_inflight < DEPTH_V);
    endcase
  end

  assign w_gnt  = imem_gnt_i && w_req;
  assign w_drop = (r_drop_cnt != '0);
  assign w_push = imem_rvalid_i && !w_drop && !redirect_i;
  assign w_pop  = id_valid_o && id_ready_i;

  always_comb begin
    w_out_nxt = r_out_cnt;
    if (w_gnt && !imem_rvalid_i)      w_out_nxt = r_out_cnt + 1'b1;
    else if (!w_gnt && imem_rvalid_i) w_out_nxt = r_out_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_out_cnt <= w_out_nxt;
      if (redirect_i) begin
        // Everything still in flight, including a grant this cycle, is stale.
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_drop_cnt <= w_out_nxt;
      end else begin
        if (w_gnt)                   r_fetch_pc <= pc_inc(r_fetch_pc);
        if (w_push)                  r_resp_pc  <= pc_inc(r_resp_pc);
        if (imem_rvalid_i && w_drop) r_drop_cnt <= r_drop_cnt - 1'b1;
      end
    end
  end

  if_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_wdata ({r_resp_pc, imem_rdata_i}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_cnt),
    .o_head  (w_head)
  );

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_fetch_pc;
  assign id_valid_o  = !w_empty;
  assign inst_o      = w_empty ? INST_NOP : w_head[31:0];
  assign addr_o      = w_empty ? 32'h0 : w_head[63:32];
  assign dbg_state_o = r_state;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));

`ifdef IF_PERF_EN
  logic [31:0] r_perf_fetch, r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_push)                    r_perf_fetch <= r_perf_fetch + 32'd1;
      if (id_valid_o && !id_ready_i) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = r_perf_fetch;
  assign perf_stall_cnt_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: imem responder, transaction-level
// reference of the fetch stream, and an expected-output queue.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        id_ready_i = 1'b0;
  logic        id_valid_o;
  logic [31:0] inst_o;
  logic [31:0] addr_o;
  if_state_e   dbg_state_o;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_stall_cnt_o;
`endif

  if_stage #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_ready_i    (id_ready_i),
    .id_valid_o    (id_valid_o),
    .inst_o        (inst_o),
    .addr_o        (addr_o),
`ifdef IF_PERF_EN
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_stall_cnt_o (perf_stall_cnt_o),
`endif
    .dbg_state_o   (dbg_state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [63:0] exp_q[$];   // {addr, inst} expected at the ID port, in order
  logic [32:0] pend_q[$];  // {stale, addr} of granted, unanswered fetches
  logic [31:0] exp_pc;
  logic [15:0] dead_n;
  bit          booted;
  int          n_cmp;
  int          n_err;
  int          n_kept;
  int          n_stall;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    id_ready_i    = 1'b0;
    #1;
    chk("rst_req",   imem_req_o,  1'b0);
    chk("rst_iaddr", imem_addr_o, RESET_PC);
    chk("rst_valid", id_valid_o,  1'b0);
    chk("rst_inst",  inst_o,      INST_NOP);
    chk("rst_addr",  addr_o,      32'h0);
    chk("rst_state", dbg_state_o, BOOT);
`ifdef IF_PERF_EN
    chk("rst_pfetch", perf_fetch_cnt_o, 32'h0);
    chk("rst_pstall", perf_stall_cnt_o, 32'h0);
`endif
    pend_q.delete();
    exp_q.delete();
    exp_pc  = RESET_PC;
    n_kept  = 0;
    n_stall = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    booted = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, then drive the inputs
  // for the next rising edge and advance the reference accordingly.
  task automatic cycle(input bit rdy, input bit gnt_ok, input bit rv_ok,
                       input bit redir, input logic [31:0] tgt);
    logic [63:0] e;
    logic [32:0] p;
    logic [31:0] d;
    @(negedge clk);
`ifdef IF_PERF_EN
    chk("perf_fetch", perf_fetch_cnt_o, n_kept);
    chk("perf_stall", perf_stall_cnt_o, n_stall);
`endif
    chk("state", dbg_state_o, booted ? RUN : BOOT);
    chk("req", imem_req_o, booted && (pend_q.size() + exp_q.size() < DEPTH));
    if (imem_req_o) chk("fetch_addr", imem_addr_o, exp_pc);
    chk("valid", id_valid_o, exp_q.size() != 0);
    if (exp_q.size() == 0) chk("nop", inst_o, INST_NOP);

    id_ready_i = rdy;
    if (id_valid_o && !rdy) n_stall++;
    if (id_valid_o && rdy && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("id_addr", addr_o, e[63:32]);
      chk("id_inst", inst_o, e[31:0]);
    end

    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (rv_ok && pend_q.size() != 0) begin
      p = pend_q.pop_front();
      imem_rvalid_i = 1'b1;
      if (p[32]) begin
        dead_n++;
        imem_rdata_i = {16'hDEAD, dead_n};
      end else begin
        d = mem_word(p[31:0]);
        imem_rdata_i = d;
        if (!redir) begin
          exp_q.push_back({p[31:0], d});
          n_kept++;
        end
      end
    end

    imem_gnt_i = imem_req_o && gnt_ok;
    if (imem_gnt_i) begin
      pend_q.push_back({1'b0, exp_pc});
      exp_pc = exp_pc + 32'd4;
    end

    redirect_i    = redir;
    redirect_pc_i = tgt;
    if (redir) begin
      for (int i = 0; i < pend_q.size(); i++) begin
        p = pend_q[i];
        p[32] = 1'b1;
        pend_q[i] = p;
      end
      exp_q.delete();
      exp_pc = {tgt[31:2], 2'b00};
    end
    booted = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; dead_n = '0;

    // Streaming: gnt always, rvalid one cycle after gnt, ID always ready
    do_reset();
    repeat (16) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Back-pressure from reset: two fetches buffered, head held at 0x0
    do_reset();
    repeat (10) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall_req",  imem_req_o, 1'b0);
    chk("stall_addr", addr_o,     32'h0);
    chk("stall_inst", inst_o,     mem_word(32'h0));
    repeat (12) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect to 0x100 with two grants still outstanding
    do_reset();
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
    repeat (12) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coinciding with a grant and an rvalid, misaligned target
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0203);
    repeat (12) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // PC wrap past 0xFFFF_FFFC
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (12) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Fill the FIFO, then reset asynchronously mid-stream
    repeat (6) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("full_valid", id_valid_o, 1'b1);
    do_reset();
    repeat (10) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    // Randomised traffic with sporadic redirects
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0, $urandom);
    end
    repeat (20) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage of the 5-stage RV32I pipeline, directly upstream of the decoder.
- Owns the PC and issues in-order requests to instruction memory over a req/gnt/rvalid protocol.
- Buffers returned words in a small FIFO and presents {instruction, address} to ID with a valid/ready handshake.
- Handles pipeline redirects (branch/jump/trap) by flushing and discarding stale responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- FIFO_DEPTH, 2, instruction buffer entries; also the maximum outstanding-plus-buffered fetches (power of 2, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_o  out  1  fetch request; held until granted.
- imem_addr_o  out  32  fetch address; word aligned, stable while req is high and not granted.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  read data valid; one per grant, in order, no earlier than the cycle after gnt.
- imem_rdata_i  in  32  instruction word.
- redirect_i  in  1  flush and restart at redirect_pc_i (from EX/MEM).
- redirect_pc_i  in  32  new PC; bits [1:0] are ignored (forced to 0).
- id_ready_i  in  1  decoder/ID register can accept.
- id_valid_o  out  1  inst_o and addr_o are valid.
- inst_o  out  32  instruction to decoder inst_i.
- addr_o  out  32  PC of inst_o, to decoder addr_i.

Behaviour:
- Reset (async assert, sync release) values:
  - imem_req_o=0, imem_addr_o=RESET_PC, id_valid_o=0, inst_o=32'h0000_0013 (NOP), addr_o=0.
  - FIFO empty; counters 0.
- Internal state:
  - fetch_pc: next address to request.
  - resp_pc: address of the next kept response.
  - out_cnt: outstanding grants.
  - drop_cnt: stale responses to discard.
  - FIFO count.
- FSM:
  - BOOT to RUN: one cycle after reset release.
  - RUN: imem_req_o=1 iff out_cnt + fifo_count < FIFO_DEPTH.
  - On gnt: fetch_pc += 4 (wraps mod 2^32), out_cnt++.
- Response handling:
  - rvalid with drop_cnt>0: word dropped, drop_cnt--.
  - rvalid with drop_cnt=0: {resp_pc, rdata} pushed, resp_pc += 4.
  - out_cnt decrements on every rvalid.
- Output:
  - id_valid_o = FIFO non-empty. inst_o/addr_o show the head; inst_o = NOP when empty.
  - Latency: rvalid in cycle N makes id_valid_o high in cycle N+1 (no combinational bypass).
  - Pop on id_valid_o && id_ready_i. Head is stable while valid and not ready.
- Credit scheme guarantees the FIFO never overflows; push to a full FIFO is an assertion failure.
- Redirect (single cycle, highest priority):
  - fetch_pc and resp_pc take {redirect_pc_i[31:2], 2'b00}; FIFO cleared.
  - drop_cnt = out_cnt + (gnt this cycle) - (rvalid this cycle).
  - If imem_req_o was high but not granted, it may change address next cycle; the next request issues the following cycle at the new PC.
- Simultaneous events:
  - redirect + gnt: the granted fetch is stale.
  - redirect + rvalid: the word is dropped.
  - redirect + id pop: the handshake completes, then the FIFO is cleared; id_valid_o=0 next cycle.
  - push + pop on the same cycle: count unchanged.
- Second redirect while drop_cnt>0: drop_cnt recomputed from current out_cnt (all in-flight responses are stale).

Optional Feature:
- Macro IF_PERF_EN.
- Defined: adds outputs perf_fetch_cnt_o[31:0] (kept responses) and perf_stall_cnt_o[31:0] (cycles with id_valid_o=1 && id_ready_i=0). Both reset to 0 and wrap.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include define.v holds:
  - INST_NOP (32'h0000_0013).
  - RESET_PC default.
  - PC width constant.
  - if_state encoding (BOOT, RUN).
- Sub-module if_fifo: synchronous FIFO, params WIDTH=64 and DEPTH; ports push, pop, flush, full, empty, count, head. Uses the same clk/rst_n.

Test Plan:
- Reset release, gnt=1 always, rvalid one cycle after gnt, id_ready=1: addresses 0x0,0x4,0x8… requested; id_valid rises 2 cycles after the first req; addr_o and inst_o match memory in order.
- id_ready_i=0 for 10 cycles: at most 2 requests granted, then imem_req_o=0; inst_o/addr_o held at 0x0; resume yields 0x4,0x8 with no loss or duplicates.
- Redirect to 0x100 with 2 outstanding: next req at 0x100; the two late rvalids (data 0xDEAD0001/2) are dropped; the first id output is addr_o=0x100.
- Redirect in the same cycle as gnt and rvalid, target 0x203 (misaligned): target forced to 0x200; exactly the correct number of stale words is dropped.
- fetch_pc at 0xFFFF_FFFC: next fetch address wraps to 0x0000_0000.
- Assert rst_n low mid-stream with FIFO full: all outputs return to reset values immediately (asynchronously); first fetch after release is RESET_PC.
